demux4_register_bank: RTL

Write-side counterpart of the 4-input muxed register bank: a single input word is steered by `select` into one of four output registers, each exposed as an independent valid/ready channel. Each channel is a one-entry buffer with backpressure toward the writer; writes to an occupied, non-draining channel are refused and counted. The block sits between a shared producer bus and four independent consumers in the lab datapath.

---
 rtl/demux4_register_bank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/demux4_register_bank.sv
// -----------------------------------------------------------------------------
// demux4_register_bank
//
// Steers one producer word into one of four one-entry output buffers, chosen
// by `select`. Each buffer is an independent valid/ready channel toward its
// consumer. A write to a buffer that is full and not being drained in the same
// cycle is refused: the data is dropped, `overflow` latches, and `drop_cnt`
// counts the refusal (saturating).
//
// Ports
//   clk                 single clock, rising edge
//   rst                 synchronous reset, active-high
//   wr_en               producer offers din this cycle
//   select [SELSIZE]    target channel code (OUT1..OUT4)
//   din    [WIDTH]      write data
//   wr_ready            combinational: a write to `select` would be accepted now
//   dout_1..dout_4      channel data registers
//   valid_1..valid_4    channel holds an unconsumed word
//   ready_1..ready_4    consumer takes the word this cycle
//   overflow            sticky: at least one write was refused
//   drop_cnt [CNTW]     refused-write count, saturating at all-ones
// -----------------------------------------------------------------------------
module demux4_register_bank #(
  parameter int                 WIDTH   = 8,
  parameter int                 SELSIZE = 2,
  parameter logic [SELSIZE-1:0] OUT1    = 2'b00,
  parameter logic [SELSIZE-1:0] OUT2    = 2'b01,
  parameter logic [SELSIZE-1:0] OUT3    = 2'b10,
  parameter logic [SELSIZE-1:0] OUT4    = 2'b11,
  parameter int                 CNTW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SELSIZE-1:0] select,
  input  logic [WIDTH-1:0]   din,
  output logic               wr_ready,
  output logic [WIDTH-1:0]   dout_1,
  output logic [WIDTH-1:0]   dout_2,
  output logic [WIDTH-1:0]   dout_3,
  output logic [WIDTH-1:0]   dout_4,
  output logic               valid_1,
  output logic               valid_2,
  output logic               valid_3,
  output logic               valid_4,
  input  logic               ready_1,
  input  logic               ready_2,
  input  logic               ready_3,
  input  logic               ready_4,
  output logic               overflow,
  output logic [CNTW-1:0]    drop_cnt
);

  logic [SELSIZE-1:0] codes [4];
  logic [3:0]         rdy;
  logic [3:0]         drain;
  logic               sel_hit;
  logic [1:0]         sel_idx;
  logic               accept;
  logic               refuse;

  logic [WIDTH-1:0]   data_p0 [4];
  logic [3:0]         vld_p0;

  assign codes[0] = OUT1;
  assign codes[1] = OUT2;
  assign codes[2] = OUT3;
  assign codes[3] = OUT4;

  assign rdy   = {ready_4, ready_3, ready_2, ready_1};
  assign drain = vld_p0 & rdy;

  // Decode select to a channel index. Scanning from the top down lets the
  // lowest-numbered channel win if two codes were ever configured equal.
  // Codes matching no channel leave sel_hit low, which forces wr_ready low.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (select == codes[i]) begin
        sel_hit = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

  // A full channel still accepts when its consumer drains in the same cycle,
  // giving back-to-back throughput with no bubble.
  assign wr_ready = sel_hit && (!vld_p0[sel_idx] || rdy[sel_idx]);
  assign accept   = wr_en && wr_ready;
  assign refuse   = wr_en && !wr_ready;

  // ---- stage p0: channel buffers and drop accounting ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        data_p0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (sel_idx == 2'(i))) begin
          data_p0[i] <= din;
          vld_p0[i]  <= 1'b1;
        end else if (drain[i]) begin
          vld_p0[i]  <= 1'b0;
        end
      end
      if (refuse) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CNTW'(1);
        end
      end
    end
  end

  assign dout_1  = data_p0[0];
  assign dout_2  = data_p0[1];
  assign dout_3  = data_p0[2];
  assign dout_4  = data_p0[3];
  assign valid_1 = vld_p0[0];
  assign valid_2 = vld_p0[1];
  assign valid_3 = vld_p0[2];
  assign valid_4 = vld_p0[3];

endmodule
